// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the data cache, bundled for port connection.
// slave = the cache itself, master = the pipeline plus memory that surround it.
interface dcache_if;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache with 128-bit line refill/write-back.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 28 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [127:0]       data_mem [LINES];

  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [127:0]       mem_wdata_q, mem_wdata_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         word;
  logic [127:0]       line;
  logic               hit;
  logic               stall, store_hit, refill_done, miss_start;

  assign idx  = bus.cpu_addr_i[4 +: INDEX_W];
  assign tag  = bus.cpu_addr_i[31 -: TAG_W];
  assign word = bus.cpu_addr_i[3:2];
  assign line = data_mem[idx];
  assign hit  = valid_q[idx] && (tag_mem[idx] == tag);

  assign bus.cpu_rdata_o = hit ? line[{word, 5'b0} +: 32] : 32'h0;
  assign bus.cpu_stall_o = stall;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;
    store_hit   = 1'b0;
    refill_done = 1'b0;
    miss_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (hit) begin
            store_hit = bus.cpu_we_i;
          end else begin
            stall      = 1'b1;
            miss_start = 1'b1;
            mem_req_d  = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d     = WRITEBACK;
              mem_we_d    = 1'b1;
              mem_addr_d  = {tag_mem[idx], idx, 4'b0};
              mem_wdata_d = line;
            end else begin
              state_d     = REFILL;
              mem_we_d    = 1'b0;
              mem_addr_d  = {tag, idx, 4'b0};
              mem_wdata_d = '0;
            end
          end
        end
      end
      WRITEBACK: begin
        stall = 1'b1;
        // The CPU address is held while stalled, so the refill target is still on the bus.
        if (bus.mem_ack_i) begin
          state_d     = REFILL;
          mem_we_d    = 1'b0;
          mem_addr_d  = {tag, idx, 4'b0};
          mem_wdata_d = '0;
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (bus.mem_ack_i) begin
          state_d     = IDLE;
          refill_done = 1'b1;
          mem_req_d   = 1'b0;
          mem_addr_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (refill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag/data arrays carry no reset; cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refill_done) begin
        data_mem[idx] <= bus.mem_rdata_i;
        tag_mem[idx]  <= tag;
      end else if (store_hit) begin
        data_mem[idx][{word, 5'b0} +: 32] <= bus.cpu_wdata_i;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic        after_refill_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // The completion cycle right after a refill is the tail of a miss, not a fresh hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      after_refill_q <= 1'b0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      after_refill_q <= refill_done;
      if (state_q == IDLE && bus.cpu_req_i && hit && !after_refill_q && hit_cnt_q != 32'hFFFF_FFFF)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_start && miss_cnt_q != 32'hFFFF_FFFF)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic against
// a line-level model of a direct-mapped write-back cache and its backing memory.
module tb_dcache_ctrl;
  localparam int LINES = 16;

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl #(.LINES(LINES)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Memory responder state and transaction log
  logic [127:0] bus_mem [logic [31:0]];
  txn_t         txn_q [$];
  int           ack_lat = 1;
  bit           resp_enable = 1'b1;
  bit           inject_ack = 1'b0;
  int           wait_cnt = 0;

  // Reference model: which line address sits at each index, its words, dirtiness, and memory image
  logic [31:0]  res_line  [int];
  logic [127:0] res_data  [int];
  bit           res_dirty [int];
  logic [127:0] mdl_mem   [logic [31:0]];
  int           exp_hits = 0;
  int           exp_misses = 0;

  function automatic logic [127:0] default_line(input logic [31:0] la);
    return {la ^ 32'hC0DE_000C, la ^ 32'hC0DE_0008, la ^ 32'hC0DE_0004, la ^ 32'hC0DE_0000};
  endfunction

  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      if (!resp_enable) begin
        bus.mem_ack_i   = inject_ack;
        bus.mem_rdata_i = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        wait_cnt        = 0;
      end else if (bus.mem_req_o && !rst) begin
        if (wait_cnt >= ack_lat - 1) begin
          wait_cnt      = 0;
          bus.mem_ack_i = 1'b1;
          txn_q.push_back('{bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o});
          if (bus.mem_we_o) bus_mem[bus.mem_addr_o] = bus.mem_wdata_o;
          else bus.mem_rdata_i = bus_mem.exists(bus.mem_addr_o) ? bus_mem[bus.mem_addr_o]
                                                                : default_line(bus.mem_addr_o);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic model_reset();
    res_line.delete();
    res_data.delete();
    res_dirty.delete();
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // One CPU access: predicts hit/write-back/refill/stall/rdata from the model, runs it, compares.
  task automatic access(input string name, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat,
                        output logic [31:0] rd, output int stalls);
    int           idx;
    int           w;
    logic [31:0]  la;
    logic [31:0]  exp_rd;
    logic [127:0] ln;
    bit           exp_hit, exp_wb;
    int           exp_stall;
    txn_t         exp_q [$];

    idx     = int'(addr[7:4]);
    w       = int'(addr[3:2]);
    la      = {addr[31:4], 4'b0};
    exp_hit = res_line.exists(idx) && res_line[idx] == la;
    exp_wb  = !exp_hit && res_line.exists(idx) && res_dirty[idx];
    if (!exp_hit) begin
      if (exp_wb) begin
        mdl_mem[res_line[idx]] = res_data[idx];
        exp_q.push_back('{1'b1, res_line[idx], res_data[idx]});
      end
      exp_q.push_back('{1'b0, la, 128'h0});
      res_line[idx]  = la;
      res_data[idx]  = mdl_mem.exists(la) ? mdl_mem[la] : default_line(la);
      res_dirty[idx] = 1'b0;
      exp_misses++;
    end else begin
      exp_hits++;
    end
    exp_stall = exp_hit ? 0 : 1 + (exp_wb ? 2 * lat : lat);
    ln        = res_data[idx];
    exp_rd    = ln[w*32 +: 32];
    if (we) begin
      ln[w*32 +: 32] = wd;
      res_data[idx]  = ln;
      res_dirty[idx] = 1'b1;
    end

    ack_lat = lat;
    txn_q.delete();
    @(posedge clk); #1;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wd;
    stalls = 0;
    rd     = '0;
    forever begin
      #4;
      if (!bus.cpu_stall_o) begin
        rd = bus.cpu_rdata_o;
        break;
      end
      stalls++;
      if (stalls > 200) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b0;
    bus.cpu_we_i  = 1'b0;
    #3;

    checks++;
    if (stalls !== exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stall);
    end
    if (!we) begin
      checks++;
      if (rd !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata: got %h expected %h", name, rd, exp_rd);
      end
    end
    checks++;
    if (txn_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s mem_txn_count: got %0d expected %0d", name, txn_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (txn_q[i].we !== exp_q[i].we || txn_q[i].addr !== exp_q[i].addr ||
            (exp_q[i].we && txn_q[i].wdata !== exp_q[i].wdata)) begin
          errors++;
          $display("FAIL %s mem_txn[%0d]: got we=%0b addr=%h wdata=%h expected we=%0b addr=%h wdata=%h",
                   name, i, txn_q[i].we, txn_q[i].addr, txn_q[i].wdata,
                   exp_q[i].we, exp_q[i].addr, exp_q[i].wdata);
        end
      end
    end
    checks++;
    if (bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s mem_req_idle: got %b expected 0", name, bus.mem_req_o);
    end
`ifdef DCACHE_STATS_EN
    checks++;
    if (hit_cnt !== exp_hits || miss_cnt !== exp_misses) begin
      errors++;
      $display("FAIL %s counters: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
               name, hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
`endif
  endtask

  task automatic test_reset();
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #5;
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.cpu_stall_o} !== 3'b000 ||
        bus.mem_addr_o !== 32'h0 || bus.mem_wdata_o !== 128'h0 || bus.cpu_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b stall=%b addr=%h wdata=%h rdata=%h expected all zero",
               bus.mem_req_o, bus.mem_we_o, bus.cpu_stall_o, bus.mem_addr_o, bus.mem_wdata_o,
               bus.cpu_rdata_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #4;
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: got req=%b stall=%b expected 0 0", bus.mem_req_o, bus.cpu_stall_o);
    end
`ifdef DCACHE_STATS_EN
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got hit=%0d miss=%0d expected 0 0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    int          st;
    access("load_0x40_miss", 1'b0, 32'h40, 32'h0, 3, rd, st);
    checks++;
    if (rd !== 32'd1 || st !== 4) begin
      errors++;
      $display("FAIL plan_load_0x40: got rdata=%h stalls=%0d expected 00000001 4", rd, st);
    end
    access("load_0x44_hit", 1'b0, 32'h44, 32'h0, 1, rd, st);
    checks++;
    if (rd !== 32'd2 || st !== 0) begin
      errors++;
      $display("FAIL plan_load_0x44: got rdata=%h stalls=%0d expected 00000002 0", rd, st);
    end
    access("store_0x48_hit", 1'b1, 32'h48, 32'hDEAD_BEEF, 1, rd, st);
    access("load_0x48_hit", 1'b0, 32'h48, 32'h0, 1, rd, st);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL plan_load_0x48: got %h expected deadbeef", rd);
    end
    access("load_0x140_dirty", 1'b0, 32'h140, 32'h0, 2, rd, st);
    checks++;
    if (st !== 5 || txn_q.size() !== 2 || txn_q[0].addr !== 32'h40 ||
        txn_q[0].wdata !== {32'd4, 32'hDEAD_BEEF, 32'd2, 32'd1} || txn_q[1].addr !== 32'h140) begin
      errors++;
      $display("FAIL plan_dirty_victim: got stalls=%0d txns=%0d expected 5 cycles, wb 0x40 then refill 0x140",
               st, txn_q.size());
    end
    access("store_0x200_miss", 1'b1, 32'h200, 32'h1234_5678, 1, rd, st);
    checks++;
    if (st !== 2 || txn_q.size() !== 1) begin
      errors++;
      $display("FAIL plan_store_miss: got stalls=%0d txns=%0d expected 2 1", st, txn_q.size());
    end
    access("load_0x200_hit", 1'b0, 32'h200, 32'h0, 1, rd, st);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL plan_load_0x200: got %h expected 12345678", rd);
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd;
    int          st;
    resp_enable = 1'b0;
    @(posedge clk); #1;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h340;
    @(posedge clk); #5;
    checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 32'h340 ||
        bus.cpu_stall_o !== 1'b1) begin
      errors++;
      $display("FAIL refill_pending: got req=%b we=%b addr=%h stall=%b expected 1 0 00000340 1",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.cpu_stall_o);
    end
    @(posedge clk); #1;
    rst           = 1'b1;
    bus.cpu_req_i = 1'b0;
    @(posedge clk); #4;
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.mem_we_o !== 1'b0 || bus.mem_addr_o !== 32'h0 ||
        bus.cpu_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: got req=%b we=%b addr=%h stall=%b expected 0 0 00000000 0",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.cpu_stall_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #4;
    inject_ack = 1'b1;
    @(posedge clk); #4;
    inject_ack = 1'b0;
    @(posedge clk); #4;
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.cpu_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_ignored: got req=%b stall=%b expected 0 0", bus.mem_req_o, bus.cpu_stall_o);
    end
    resp_enable = 1'b1;
    access("load_0x40_after_reset", 1'b0, 32'h40, 32'h0, 2, rd, st);
    checks++;
    if (st !== 3 || rd !== 32'd1) begin
      errors++;
      $display("FAIL reload_after_reset: got stalls=%0d rdata=%h expected 3 00000001", st, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] addr;
    int          st;
    for (int n = 0; n < 80; n++) begin
      addr = {22'h0, 2'($urandom_range(3)), 4'($urandom_range(15)), 2'($urandom_range(3)), 2'b00};
      access("random", 1'($urandom_range(1)), addr, $urandom, int'($urandom_range(4, 1)), rd, st);
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    logic [31:0] rd;
    logic [31:0] h0, m0;
    int          st;
    access("stats_warm", 1'b0, 32'h500, 32'h0, 1, rd, st);
    h0 = hit_cnt;
    m0 = miss_cnt;
    access("stats_hit0", 1'b0, 32'h500, 32'h0, 1, rd, st);
    access("stats_hit1", 1'b0, 32'h504, 32'h0, 1, rd, st);
    access("stats_miss", 1'b0, 32'h600, 32'h0, 2, rd, st);
    checks++;
    if (hit_cnt - h0 !== 32'd2 || miss_cnt - m0 !== 32'd1) begin
      errors++;
      $display("FAIL stats_sequence: got hit_delta=%0d miss_delta=%0d expected 2 1",
               hit_cnt - h0, miss_cnt - m0);
    end
  endtask
`endif

  initial begin
    bus_mem[32'h40] = {32'd4, 32'd3, 32'd2, 32'd1};
    mdl_mem[32'h40] = {32'd4, 32'd3, 32'd2, 32'd1};
    test_reset();
    test_directed();
    test_reset_mid_refill();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
